// File: rtl/hyperbus_conv_pkg.sv
// Shared types and helpers for the HyperBus data-path width converters.
// Lane masks are built at full AXI width and sliced by the user.
package hyperbus_conv_pkg;

  typedef enum logic [1:0] {
    Idle,
    Collect,
    Emit
  } state_e;

  localparam int unsigned MaxAxiBytes = 128;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_beat_t;

  function automatic int unsigned NumAxiBytes(
    input int unsigned width
  );
    return width / 8;
  endfunction

  function automatic int unsigned PhyBytes(
    input int unsigned num_phys
  );
    return 2 * num_phys;
  endfunction

  function automatic int unsigned WordCntWidth(
    input int unsigned width,
    input int unsigned num_phys
  );
    return $clog2(width / 8) - $clog2(2 * num_phys) + 1;
  endfunction

  function automatic logic [MaxAxiBytes-1:0] lane_mask(
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    logic [MaxAxiBytes-1:0] m;
    m = '0;
    for (int i = 0; i < MaxAxiBytes; i++) begin
      m[i] = (8'(i) >= lo) && (8'(i) < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/hyperbus_lane_window.sv
// Byte-lane window [lo,hi) of one AXI beat from address and size.
// Purely combinational; shared between write and read paths.
module hyperbus_lane_window
  import hyperbus_conv_pkg::*;
#(
  parameter int unsigned AddrWidth = 3
) (
  input  logic [AddrWidth-1:0]      addr,
  input  logic [2:0]                size,
  output logic [AddrWidth-1:0]      lo,
  output logic [AddrWidth:0]        hi,
  output logic [(1<<AddrWidth)-1:0] mask
);

  logic [AddrWidth:0]     step;
  logic [MaxAxiBytes-1:0] full;
  logic                   unused_full;

  assign step = (AddrWidth+1)'(1) << size;
  assign lo   = addr;
  assign hi   = ({1'b0, addr} & ~(step - 1'b1)) + step;
  assign full = lane_mask(8'(addr), 8'(hi));
  assign mask = full[(1<<AddrWidth)-1:0];

  assign unused_full = ^full;

endmodule

// File: rtl/hyperbus_wdata_conv.sv
// AXI W beats to aligned HyperBus PHY words: downsizes wide beats,
// packs narrow beats, masks strobes and checks burst length.
module hyperbus_wdata_conv
  import hyperbus_conv_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned NumPhys      = 2,
  parameter int unsigned BurstLength  = 8,
  parameter type         T            = w_beat_t,
  parameter int unsigned AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   trans_valid_i,
  output logic                   trans_ready_o,
  input  logic [AddrWidth-1:0]   start_addr_i,
  input  logic [2:0]             size_i,
  input  logic [BurstLength-1:0] len_i,
  input  logic                   axi_valid_i,
  output logic                   axi_ready_o,
  input  T                       data_i,
  output logic                   phy_valid_o,
  input  logic                   phy_ready_i,
  output logic [16*NumPhys-1:0]  data_o,
  output logic [2*NumPhys-1:0]   strb_o,
  output logic                   last_o,
  output logic                   len_mismatch_o
);

  localparam int unsigned AxiB     = NumAxiBytes(AxiDataWidth);
  localparam int unsigned PhyB     = PhyBytes(NumPhys);
  localparam int unsigned PhyBits  = 8 * PhyB;
  localparam int unsigned PhyShift = $clog2(PhyB);
  localparam int unsigned IdxW     = WordCntWidth(AxiDataWidth, NumPhys);
  localparam logic [2:0]  WideSize = 3'(PhyShift);
  localparam logic [AddrWidth:0] PhyStep  = (AddrWidth+1)'(PhyB);
  localparam logic [AddrWidth:0] PhyAlign = ~(PhyStep - 1'b1);

  state_e                  state_q;
  logic [AddrWidth-1:0]    addr_q;
  logic [2:0]              size_q;
  logic [BurstLength-1:0]  cnt_q;
  logic [AddrWidth:0]      ptr_q;
  logic [AddrWidth:0]      hi_q;
  logic                    end_q;
  logic                    trans_ready_q;
  logic [AxiDataWidth-1:0] buf_data_q;
  logic [AxiB-1:0]         buf_strb_q;

  logic [AddrWidth-1:0]    win_lo;
  logic [AddrWidth:0]      win_hi;
  logic [AxiB-1:0]         win_mask;
  logic [AxiDataWidth-1:0] new_data;
  logic [AxiB-1:0]         new_strb;
  logic [AddrWidth:0]      ptr_nxt;
  logic [IdxW-1:0]         word_idx;
  logic                    word_done;
  logic                    phy_fire;
  logic                    beat_fire;
  logic                    cnt_zero;
  logic                    term;
  logic                    go_emit;
  logic                    unused_user;

  hyperbus_lane_window #(
    .AddrWidth(AddrWidth)
  ) u_win (
    .addr(addr_q),
    .size(size_q),
    .lo  (win_lo),
    .hi  (win_hi),
    .mask(win_mask)
  );

  assign ptr_nxt   = ptr_q + PhyStep;
  assign word_done = ptr_nxt >= hi_q;
  assign word_idx  = ptr_q[AddrWidth:PhyShift];

  assign trans_ready_o = trans_ready_q;
  assign phy_valid_o   = (state_q == Emit);
  assign phy_fire      = phy_valid_o & phy_ready_i;
  assign last_o        = phy_valid_o & end_q & word_done;

  // Refill straight from Emit so wide beats stream without a bubble.
  assign axi_ready_o = (state_q == Collect) |
                       (phy_fire & word_done & ~end_q);
  assign beat_fire   = axi_valid_i & axi_ready_o;

  assign cnt_zero = (cnt_q == '0);
  assign term     = data_i.last | cnt_zero;
  assign go_emit  = (size_q >= WideSize) |
                    (win_hi[PhyShift-1:0] == '0) | term;

  assign len_mismatch_o = beat_fire & (data_i.last ^ cnt_zero);
  assign unused_user    = ^data_i.user;

  always_comb begin
    new_data = '0;
    new_strb = '0;
    if (state_q == Collect) begin
      new_data = buf_data_q;
      new_strb = buf_strb_q;
    end
    for (int i = 0; i < AxiB; i++) begin
      if (win_mask[i]) begin
        new_data[i*8 +: 8] = data_i.data[i*8 +: 8];
        new_strb[i]        = data_i.strb[i];
      end
    end
  end

  always_comb begin
    data_o = '0;
    strb_o = '0;
    for (int w = 0; w < AxiB / PhyB; w++) begin
      if (word_idx == IdxW'(w)) begin
        data_o = buf_data_q[w*PhyBits +: PhyBits];
        strb_o = buf_strb_q[w*PhyB +: PhyB];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= Idle;
      addr_q        <= '0;
      size_q        <= '0;
      cnt_q         <= '0;
      ptr_q         <= '0;
      hi_q          <= '0;
      end_q         <= 1'b0;
      trans_ready_q <= 1'b0;
      buf_data_q    <= '0;
      buf_strb_q    <= '0;
    end else begin
      unique case (state_q)
        Idle: begin
          trans_ready_q <= 1'b1;
          if (trans_valid_i & trans_ready_q) begin
            addr_q        <= start_addr_i;
            size_q        <= (size_i > 3'(AddrWidth)) ?
                             3'(AddrWidth) : size_i;
            cnt_q         <= len_i;
            end_q         <= 1'b0;
            trans_ready_q <= 1'b0;
            state_q       <= Collect;
          end
        end
        Collect: ;
        Emit: begin
          if (phy_fire) begin
            if (word_done) begin
              buf_data_q <= '0;
              buf_strb_q <= '0;
              if (end_q) begin
                trans_ready_q <= 1'b1;
                state_q       <= Idle;
              end else begin
                state_q <= Collect;
              end
            end else begin
              ptr_q <= ptr_nxt;
            end
          end
        end
        default: state_q <= Idle;
      endcase

      if (beat_fire) begin
        buf_data_q <= new_data;
        buf_strb_q <= new_strb;
        addr_q     <= win_hi[AddrWidth-1:0];
        ptr_q      <= {1'b0, win_lo} & PhyAlign;
        hi_q       <= win_hi;
        end_q      <= term;
        state_q    <= go_emit ? Emit : Collect;
        if (!cnt_zero) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_wdata_conv.sv
// Scoreboard bench for hyperbus_wdata_conv: directed bursts,
// PHY back-pressure, early last and mid-burst reset.
module tb_hyperbus_wdata_conv;
  import hyperbus_conv_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [31:0] dmask;
    logic [3:0]  strb;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        trans_valid;
  logic        trans_ready;
  logic [2:0]  start_addr;
  logic [2:0]  size;
  logic [7:0]  len;
  logic        axi_valid;
  logic        axi_ready;
  w_beat_t     beat;
  logic        phy_valid;
  logic        phy_ready;
  logic [31:0] data_o;
  logic [3:0]  strb_o;
  logic        last_o;
  logic        mism;

  int tests_run = 0;
  int fails = 0;
  int hs_words = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stalled = 0;
  bit hold_ready = 0;
  bit prev_stall = 0;
  logic [31:0] hold_data;
  logic [3:0]  hold_strb;
  logic        hold_last;

  exp_t sb_q[$];
  bit   mm_q[$];

  hyperbus_wdata_conv #(
    .AxiDataWidth(64),
    .NumPhys     (2),
    .BurstLength (8),
    .T           (w_beat_t)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .trans_valid_i (trans_valid),
    .trans_ready_o (trans_ready),
    .start_addr_i  (start_addr),
    .size_i        (size),
    .len_i         (len),
    .axi_valid_i   (axi_valid),
    .axi_ready_o   (axi_ready),
    .data_i        (beat),
    .phy_valid_o   (phy_valid),
    .phy_ready_i   (phy_ready),
    .data_o        (data_o),
    .strb_o        (strb_o),
    .last_o        (last_o),
    .len_mismatch_o(mism)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (hold_ready) begin
      phy_ready = 1'b0;
    end else if (phy_valid && hs_words == stall_at &&
                 stalled < stall_len) begin
      phy_ready = 1'b0;
      stalled++;
    end else begin
      phy_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (phy_valid && phy_ready) begin
        hs_words++;
        if (sb_q.size() == 0) begin
          check(0, "unexpected_word", {32'h0, data_o}, 64'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check((data_o & e.dmask) == (e.data & e.dmask),
                "word_data", {32'h0, data_o & e.dmask},
                {32'h0, e.data & e.dmask});
          check(strb_o == e.strb, "word_strb",
                64'(strb_o), 64'(e.strb));
          check(last_o == e.last, "word_last",
                64'(last_o), 64'(e.last));
        end
      end
      if (axi_valid && axi_ready) begin
        if (mm_q.size() == 0) begin
          check(0, "unexpected_beat", 64'(mism), 64'h0);
        end else begin
          bit m;
          m = mm_q.pop_front();
          check(mism == m, "len_mismatch", 64'(mism), 64'(m));
        end
      end
      if (phy_valid && !phy_ready) begin
        if (prev_stall) begin
          check(data_o == hold_data && strb_o == hold_strb &&
                last_o == hold_last, "stall_hold",
                {28'h0, strb_o, data_o},
                {28'h0, hold_strb, hold_data});
        end
        check(axi_ready == 1'b0, "stall_axi_ready",
              64'(axi_ready), 64'h0);
        hold_data  = data_o;
        hold_strb  = strb_o;
        hold_last  = last_o;
        prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic push_word(input logic [31:0] d,
                           input logic [31:0] m,
                           input logic [3:0] s,
                           input logic l);
    exp_t e;
    e.data  = d;
    e.dmask = m;
    e.strb  = s;
    e.last  = l;
    sb_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [2:0] a,
                          input logic [2:0] sz,
                          input logic [7:0] ln);
    bit ok;
    ok = 0;
    start_addr  = a;
    size        = sz;
    len         = ln;
    trans_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trans_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    trans_valid = 1'b0;
    if (!ok) check(0, "cmd_timeout", 64'h0, 64'h1);
  endtask

  task automatic send_beat(input logic [63:0] d,
                           input logic [7:0] s,
                           input logic l,
                           input int budget,
                           output bit fired);
    fired     = 0;
    beat.data = d;
    beat.strb = s;
    beat.last = l;
    beat.user = 1'b0;
    axi_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (axi_ready) begin
        fired = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    axi_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && trans_ready) break;
      @(negedge clk);
    end
    check(sb_q.size() == 0, name, 64'(sb_q.size()), 64'h0);
    check(trans_ready == 1'b1, "idle_ready",
          64'(trans_ready), 64'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_t1(input string name);
    bit f;
    push_word(32'h55667788, '1, 4'hF, 0);
    push_word(32'h11223344, '1, 4'hF, 0);
    push_word(32'hDDEEFF00, '1, 4'hF, 0);
    push_word(32'h99AABBCC, '1, 4'hF, 1);
    mm_q.push_back(0);
    mm_q.push_back(0);
    send_cmd(3'd0, 3'd3, 8'd1);
    send_beat(64'h1122334455667788, 8'hFF, 0, 50, f);
    check(f, "beat0_accept", 64'(f), 64'h1);
    send_beat(64'h99AABBCCDDEEFF00, 8'hFF, 1, 50, f);
    check(f, "beat1_accept", 64'(f), 64'h1);
    wait_drain(name);
  endtask

  initial begin
    bit f;
    rst_n       = 1'b0;
    trans_valid = 1'b0;
    start_addr  = '0;
    size        = '0;
    len         = '0;
    axi_valid   = 1'b0;
    beat        = '0;
    phy_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check({phy_valid, axi_ready, trans_ready, last_o, mism,
           strb_o, data_o} == '0, "reset_outputs",
          {23'h0, phy_valid, axi_ready, trans_ready, last_o,
           mism, strb_o, data_o}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: aligned 64-bit beats downsized to four words
    run_t1("t1_drain");

    // 2: unaligned single beat at byte 6
    push_word(32'h11220000, 32'hFFFF0000, 4'b1100, 1);
    mm_q.push_back(0);
    send_cmd(3'd6, 3'd3, 8'd0);
    send_beat(64'h1122334455667788, 8'hFF, 1, 50, f);
    check(f, "t2_accept", 64'(f), 64'h1);
    wait_drain("t2_drain");

    // 3: byte beats packed into two words
    push_word(32'hA3A2A100, 32'hFFFFFF00, 4'b1110, 0);
    push_word(32'h00A6A5A4, 32'h00FFFFFF, 4'b0111, 1);
    for (int k = 0; k < 6; k++) mm_q.push_back(0);
    send_cmd(3'd1, 3'd0, 8'd5);
    for (int k = 0; k < 6; k++) begin
      logic [63:0] d;
      d = 64'(8'hA1 + 8'(k)) << (8 * (k + 1));
      send_beat(d, 8'hFF, k == 5, 50, f);
      check(f, "t3_accept", 64'(f), 64'h1);
    end
    wait_drain("t3_drain");

    // 4: back-pressure on the third word
    stall_at  = hs_words + 2;
    stall_len = 5;
    stalled   = 0;
    run_t1("t4_drain");
    check(stalled == 5, "t4_stall_seen", 64'(stalled), 64'd5);
    stall_at = -1;

    // 5: early last on beat 1 of a 4-beat burst
    push_word(32'h89ABCDEF, '1, 4'hF, 0);
    push_word(32'h01234567, '1, 4'hF, 0);
    push_word(32'h76543210, '1, 4'hF, 0);
    push_word(32'hFEDCBA98, '1, 4'hF, 1);
    mm_q.push_back(0);
    mm_q.push_back(1);
    send_cmd(3'd0, 3'd3, 8'd3);
    send_beat(64'h0123456789ABCDEF, 8'hFF, 0, 50, f);
    check(f, "t5_beat0", 64'(f), 64'h1);
    send_beat(64'hFEDCBA9876543210, 8'hFF, 1, 50, f);
    check(f, "t5_beat1", 64'(f), 64'h1);
    wait_drain("t5_drain");
    send_beat(64'h5555AAAA5555AAAA, 8'hFF, 0, 10, f);
    check(!f, "t5_extra_refused", 64'(f), 64'h0);

    // 6: reset while a word is pending
    hold_ready = 1;
    mm_q.push_back(0);
    send_cmd(3'd0, 3'd3, 8'd1);
    send_beat(64'h1122334455667788, 8'hFF, 0, 50, f);
    check(f, "t6_accept", 64'(f), 64'h1);
    f = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (phy_valid) begin
        f = 1;
        break;
      end
    end
    check(f, "t6_emit_seen", 64'(f), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check({phy_valid, axi_ready, trans_ready, last_o, mism,
           strb_o, data_o} == '0, "t6_reset_outputs",
          {23'h0, phy_valid, axi_ready, trans_ready, last_o,
           mism, strb_o, data_o}, 64'h0);
    sb_q.delete();
    mm_q.delete();
    hold_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_t1("t6_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
